des_round_ctrl: RTL and testbench
=================================

// Module: des_round_ctrl
// PURPOSE
//  Sequencer for the iterative DES core: accepts one block request, pulses the L/R and C/D load,
//  then steps the shared round datapath (E-expand, key XOR, SBox1..SBox8, P-permute) once per round.
//  Drives round index and per-round key-schedule rotate amount/direction (encrypt/decrypt).
//  Sits between the host handshake and the round datapath; holds no data, only control.
// PARAMETERS
//  ROUNDS   16  rounds per block; legal 1..16; shift table indexed by round_idx
//  IDX_W     4  width of round_idx; must satisfy 2**IDX_W >= ROUNDS
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start_valid  in   1      host requests a block operation
//  start_ready  out  1      controller can accept (IDLE only)
//  decrypt      in   1      mode, sampled on start handshake (0 enc, 1 dec)
//  abort        in   1      synchronous cancel, any state
//  load         out  1      one-cycle pulse: datapath captures data into L/R, key into C/D
//  round_en     out  1      datapath registers one round result this cycle
//  round_idx    out  IDX_W  current round, 0..ROUNDS-1; 0 when idle
//  key_shift    out  2      C/D rotate amount applied in this round (0,1,2)
//  key_dir      out  1      0 rotate left (enc), 1 rotate right (dec)
//  last_round   out  1      high with round_en on final round: datapath skips L/R swap
//  busy         out  1      high in LOAD/ROUND/SBOX_WAIT/DONE
//  done_valid   out  1      result in datapath output register is valid
//  done_ready   in   1      host consumes result
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, round_idx=0, mode=0; start_ready=1, all other outputs 0.
//  States: IDLE -> LOAD -> ROUND [-> SBOX_WAIT -> ROUND ...] -> DONE -> IDLE.
//  IDLE: start_ready=1; start_valid&start_ready -> latch decrypt into mode, go LOAD.
//  LOAD: load=1 for exactly one cycle; round_idx=0; go ROUND.
//  ROUND: round_en=1; key_shift/key_dir valid same cycle, applied by datapath before subkey use.
//   Encrypt shifts by idx 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0.
//   Decrypt shifts by idx: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=1 (idx0 shift 0).
//   round_idx increments after each round_en; at round_idx==ROUNDS-1: last_round=1, go DONE.
//  DONE: done_valid=1, held stable until done_ready; done_valid&done_ready -> IDLE next cycle,
//   round_idx cleared to 0. No accept in same cycle as done handshake (start_ready=0 in DONE).
//  Latency (no macro): handshake at cycle T; load at T+1; round_en T+2..T+ROUNDS+1;
//   done_valid from T+ROUNDS+2 (T+18 for 16 rounds).
//  start_valid outside IDLE ignored; decrypt changes after handshake have no effect.
//  abort: highest priority over every transition; next state IDLE, outputs to reset values,
//   no done_valid for cancelled block; abort in IDLE is a no-op; abort and start_valid together
//   in IDLE -> request not accepted.
//  rst_n asserted mid-operation: immediate return to reset values; block lost.
//  round_idx never exceeds ROUNDS-1; no wrap.
// CONFIGURATION
//  DES_SBOX_PIPE_EN defined: datapath has a register after the S-box stage; each round takes 2
//   cycles: SBOX_WAIT-first phase (round_en=0, key_shift/key_dir/round_idx already presented and
//   held stable), then ROUND phase with round_en=1. Shift is applied once per round (on round_en).
//   Latency: done_valid from T+2*ROUNDS+2 (T+34). abort/reset priorities unchanged.
//  Not defined: SBOX_WAIT state absent; single-cycle rounds as above.
// TESTING
//  1 Reset: rst_n=0 -> start_ready=1, load=round_en=done_valid=busy=0, round_idx=0.
//  2 Encrypt: start_valid=1,decrypt=0 at T -> load at T+1, 16 round_en T+2..T+17 with
//    key_shift seq 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0, last_round only at T+17,
//    done_valid at T+18; plus end-to-end with datapath: key 133457799BBCDFF1, pt 0123456789ABCDEF
//    -> ct 85E813540F0AB405.
//  3 Decrypt: decrypt=1 -> key_shift seq 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=1; ct 85E813540F0AB405
//    -> pt 0123456789ABCDEF.
//  4 Backpressure: done_ready=0 for 10 cycles -> done_valid held, start_valid ignored, start_ready=0;
//    done_ready=1 -> IDLE next cycle, new request accepted the cycle after.
//  5 Abort at round_idx=7 -> IDLE next cycle, no done_valid, round_idx=0; rst_n pulse at round 3 same.
//  6 DES_SBOX_PIPE_EN: round_en every 2nd cycle, key_shift stable both phases, done_valid at T+34.

Source files
------------

// File: rtl/des_round_ctrl.sv
// Control sequencer for an iterative DES round datapath: host handshake, L/R + C/D load, per-round key schedule shifts.
// Optional DES_SBOX_PIPE_EN: each round gets a leading SBOX_WAIT phase for a registered S-box stage.
module des_round_ctrl #(
    parameter int ROUNDS = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             decrypt,
    input  logic             abort,
    output logic             load,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic [1:0]       key_shift,
    output logic             key_dir,
    output logic             last_round,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
`ifdef DES_SBOX_PIPE_EN
    localparam logic [2:0] S_WAIT  = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_mode;
    logic [2:0]       w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_mode_nxt;
    logic             w_in_round;

    // Decrypt walks the schedule backwards, so its first subkey uses C/D as loaded (shift 0).
    function automatic logic [1:0] shift_amt(input logic [IDX_W-1:0] idx, input logic dec);
        int i;
        i = int'(idx);
        if (i == 0)
            return dec ? 2'd0 : 2'd1;
        if (i == 1 || i == 8 || i == 15)
            return 2'd1;
        return 2'd2;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mode_nxt  = r_mode;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_mode_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        w_state_nxt = S_LOAD;
                        w_mode_nxt  = decrypt;
                        w_idx_nxt   = '0;
                    end
                end
                S_LOAD: begin
                    w_idx_nxt = '0;
`ifdef DES_SBOX_PIPE_EN
                    w_state_nxt = S_WAIT;
`else
                    w_state_nxt = S_ROUND;
`endif
                end
                S_ROUND: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
`ifdef DES_SBOX_PIPE_EN
                        w_state_nxt = S_WAIT;
`else
                        w_state_nxt = S_ROUND;
`endif
                    end
                end
`ifdef DES_SBOX_PIPE_EN
                S_WAIT:  w_state_nxt = S_ROUND;
`endif
                S_DONE: begin
                    if (done_ready) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Shift/direction are presented for the whole round, including its wait phase.
`ifdef DES_SBOX_PIPE_EN
    assign w_in_round = (r_state == S_ROUND) || (r_state == S_WAIT);
`else
    assign w_in_round = (r_state == S_ROUND);
`endif

    assign start_ready = (r_state == S_IDLE);
    assign load        = (r_state == S_LOAD);
    assign round_en    = (r_state == S_ROUND);
    assign round_idx   = r_idx;
    assign key_shift   = w_in_round ? shift_amt(r_idx, r_mode) : 2'd0;
    assign key_dir     = w_in_round & r_mode;
    assign last_round  = (r_state == S_ROUND) && (r_idx == LAST_IDX);
    assign busy        = (r_state != S_IDLE);
    assign done_valid  = (r_state == S_DONE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Randomized + directed bench for des_round_ctrl against a cycle-count reference model.
module tb_des_round_ctrl;
    localparam int ROUNDS = 16;
`ifdef DES_SBOX_PIPE_EN
    localparam int RC = 2;
`else
    localparam int RC = 1;
`endif
    localparam int LAT = ROUNDS * RC + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid, decrypt, abort, done_ready;
    logic       start_ready, load, round_en, key_dir, last_round, busy, done_valid;
    logic [3:0] round_idx;
    logic [1:0] key_shift;

    int n_checks = 0;
    int n_err = 0;
    int ENC_SH[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int DEC_SH[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    des_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .decrypt(decrypt), .abort(abort), .load(load), .round_en(round_en),
        .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
        .last_round(last_round), .busy(busy), .done_valid(done_valid), .done_ready(done_ready)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 in block (m_c = cycles since handshake), 2 waiting for done_ready.
    int m_phase = 0;
    int m_c = 0;
    bit m_mode = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_c <= 0; m_mode <= 1'b0;
        end else if (abort) begin
            m_phase <= 0; m_c <= 0; m_mode <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin m_phase <= 1; m_c <= 1; m_mode <= decrypt; end
                1: if (m_c == LAT - 1) begin m_phase <= 2; m_c <= LAT; end else m_c <= m_c + 1;
                default: if (done_ready) begin m_phase <= 0; m_c <= 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        bit inr, ren;
        int r, e_idx, e_sh;
        inr   = (m_phase == 1) && (m_c >= 2);
        r     = inr ? (m_c - 2) / RC : 0;
        ren   = inr && (((m_c - 2) % RC) == RC - 1);
        e_idx = inr ? r : ((m_phase == 2) ? ROUNDS - 1 : 0);
        e_sh  = inr ? (m_mode ? DEC_SH[r] : ENC_SH[r]) : 0;
        check("start_ready", int'(start_ready), int'(m_phase == 0));
        check("busy",        int'(busy),        int'(m_phase != 0));
        check("load",        int'(load),        int'(m_phase == 1 && m_c == 1));
        check("round_en",    int'(round_en),    int'(ren));
        check("round_idx",   int'(round_idx),   e_idx);
        check("key_shift",   int'(key_shift),   e_sh);
        check("key_dir",     int'(key_dir),     int'(inr && m_mode));
        check("last_round",  int'(last_round),  int'(ren && r == ROUNDS - 1));
        check("done_valid",  int'(done_valid),  int'(m_phase == 2));
    end

    task automatic run_block(input bit dec);
        int load_at, n_en, last_at, done_at, dir_bad;
        logic [31:0] sh_pack;
        load_at = 0; n_en = 0; last_at = 0; done_at = 0; dir_bad = 0; sh_pack = '0;
        @(negedge clk); #1 start_valid = 1'b1; decrypt = dec; done_ready = 1'b0;
        for (int k = 1; k <= 80 && done_at == 0; k++) begin
            @(negedge clk);
            if (load) load_at = k;
            if (round_en) begin
                if (n_en < 16) sh_pack[2*n_en +: 2] = key_shift;
                if (key_dir != dec) dir_bad++;
                if (last_round) last_at = k;
                n_en++;
            end
            if (done_valid) done_at = k;
            if (k == 1) begin #1 start_valid = 1'b0; decrypt = ~dec; end
        end
        check("blk_load_cycle", load_at, 1);
        check("blk_round_count", n_en, 16);
        check("blk_last_cycle", last_at, LAT - 1);
        check("blk_done_cycle", done_at, LAT);
        check("blk_shift_seq", int'(sh_pack), dec ? 32'h6AA9AAA4 : 32'h6AA9AAA5);
        check("blk_dir", dir_bad, 0);
        // Backpressure on the result; new requests must be ignored meanwhile.
        #1 start_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_done_held", int'(done_valid), 1);
            check("bp_no_accept", int'(start_ready), 0);
        end
        #1 done_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after", int'(start_ready), 1);
        check("bp_done_clear", int'(done_valid), 0);
        #1 done_ready = 1'b0;
        @(negedge clk);
        check("bp_new_load", int'(load), 1);
        #1 start_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        check("abort_in_load", int'(busy), 0);
        #1 abort = 1'b0;
    endtask

    task automatic start_op(input bit dec);
        @(negedge clk); #1 start_valid = 1'b1; decrypt = dec;
        @(negedge clk); #1 start_valid = 1'b0;
    endtask

    initial begin
        int seen;
        start_valid = 1'b0; decrypt = 1'b0; abort = 1'b0; done_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_start_ready", int'(start_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_idx", int'(round_idx), 0);
        #1 rst_n = 1'b1;

        run_block(1'b0);
        run_block(1'b1);

        // Abort at round 7: no result may appear afterwards.
        start_op(1'b0);
        seen = 0;
        for (int k = 0; k < 60 && seen == 0; k++) begin
            @(negedge clk);
            if (round_en && round_idx == 4'd7) seen = 1;
        end
        check("abort_reached_r7", seen, 1);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_idle", int'(start_ready), 1);
        check("abort_idx", int'(round_idx), 0);
        #1 abort = 1'b0; done_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_valid) seen = 1;
        end
        check("abort_no_done", seen, 0);

        // Abort together with a request in idle: not accepted.
        #1 abort = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        check("abort_blocks_start", int'(busy), 0);
        #1 abort = 1'b0; start_valid = 1'b0;

        // Asynchronous reset mid-block.
        start_op(1'b1);
        seen = 0;
        for (int k = 0; k < 60 && seen == 0; k++) begin
            @(negedge clk);
            if (round_idx == 4'd3) seen = 1;
        end
        check("rst_reached_r3", seen, 1);
        #1 rst_n = 1'b0;
        #2;
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_idx", int'(round_idx), 0);
        check("rst_async_ready", int'(start_ready), 1);
        @(negedge clk); #1 rst_n = 1'b1;

        // Random traffic checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            start_valid = ($urandom_range(0, 1) == 1);
            decrypt     = ($urandom_range(0, 1) == 1);
            abort       = ($urandom_range(0, 49) == 0);
            done_ready  = ($urandom_range(0, 2) == 0);
            rst_n       = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk); #1 rst_n = 1'b1; start_valid = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
